// File: rtl/fir_pkg.sv
// Shared definitions for the halfband FIR stages (decimator and interpolator).
//
// Contents:
//   DW, CW, AW      - sample, coefficient and accumulator widths
//   HB1_C0..HB1_C5  - halfband prototype taps h0, h2, h4, h5 in Q5.20
//                     (the Q1.20 prototype values, sign-extended to CW bits)
//   state_t         - sequencing states of the x2 interpolator
//
// The optional output saturation macro HB_INTERP_SAT_EN is consumed by
// hb_interp2; nothing in this package depends on it.
package fir_pkg;

    localparam int DW = 18;
    localparam int CW = 25;
    localparam int AW = 48;

    // 11-tap halfband: h1 = h3 = h7 = h9 = 0 and h5 = 0.5. The taps are
    // symmetric, so only h0, h2 and h4 are stored for the pre-added pairs.
    localparam logic signed [CW-1:0] HB1_C0 = 25'sh0002090;  //  8336
    localparam logic signed [CW-1:0] HB1_C2 = 25'sh1FF2158;  // -57000
    localparam logic signed [CW-1:0] HB1_C4 = 25'sh004BE38;  //  310840
    localparam logic signed [CW-1:0] HB1_C5 = 25'sh0080000;  //  524288 (0.5)

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC0 = 3'd1,
        ST_MAC1 = 3'd2,
        ST_MAC2 = 3'd3,
        ST_OUT0 = 3'd4,
        ST_OUT1 = 3'd5
    } state_t;

endpackage

// File: rtl/hb_preadd_mac.sv
// Symmetric pre-add multiply-accumulate slice: acc <= (a + b) * coef + acc.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears acc)
//   en        - update the accumulator this cycle
//   clr       - treat the previous accumulator as zero (first term of a sum)
//   a, b      - signed DW-bit samples forming the symmetric pair
//   coef      - signed CW-bit coefficient
//   acc_next  - combinational value the accumulator takes when en is high
module hb_preadd_mac #(
    parameter int DW = 18,
    parameter int CW = 25,
    parameter int AW = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic signed [CW-1:0] coef,
    output logic signed [AW-1:0] acc_next
);

    localparam int PW = DW + 1 + CW;

    logic signed [DW:0]   pre;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_base;

    // One extra bit so the pair sum never overflows.
    assign pre  = {a[DW-1], a} + {b[DW-1], b};
    assign prod = pre * coef;

    assign acc_base = clr ? '0 : acc_q;
    assign acc_next = acc_base + {{(AW-PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/hb_interp2.sv
// Halfband x2 interpolator. Every accepted input produces two outputs:
//   y0 (branch A) = 2*(h0*(x0+x5) + h2*(x1+x4) + h4*(x2+x3)), rounded half up
//   y1 (branch B) = x2 (2*h5 == 1, so no multiply is needed)
// Branch A runs on one shared pre-add MAC over three cycles.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   s_valid/s_ready    - input handshake, s_data is a signed DW-bit sample
//   m_valid/m_ready    - output handshake, m_data is a signed DW-bit sample
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holding valid keeps its data stable until the
// transfer; m_valid/m_data never change while m_valid=1 and m_ready=0.
//
// Build option: define HB_INTERP_SAT_EN to clamp y0 into the DW-bit range;
// without it y0 keeps its low DW bits (two's-complement wrap).
module hb_interp2 #(
    parameter int DW = fir_pkg::DW,
    parameter int CW = fir_pkg::CW,
    parameter int AW = fir_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    import fir_pkg::*;

    // acc holds y0 * 2^19 (Q1.20 coefficients with the factor of two folded in).
    localparam int RND_SHIFT = 19;
    localparam logic signed [AW-1:0] RND_HALF = AW'(longint'(1) <<< (RND_SHIFT - 1));

    state_t               state_q;
    state_t               state_d;
    logic signed [DW-1:0] x_q [6];
    logic                 s_ready_q;
    logic                 m_valid_q;
    logic [DW-1:0]        m_data_q;

    logic                 mac_en;
    logic                 mac_clr;
    logic signed [DW-1:0] mac_a;
    logic signed [DW-1:0] mac_b;
    logic signed [CW-1:0] mac_coef;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] acc_rnd;
    logic signed [AW-1:0] y0_full;
    logic [DW-1:0]        y0;

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (s_valid) state_d = ST_MAC0;
            ST_MAC0: state_d = ST_MAC1;
            ST_MAC1: state_d = ST_MAC2;
            ST_MAC2: state_d = ST_OUT0;
            ST_OUT0: if (m_ready) state_d = ST_OUT1;
            ST_OUT1: if (m_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mac_a    = x_q[0];
        mac_b    = x_q[5];
        mac_coef = HB1_C0;
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        case (state_q)
            ST_MAC0: begin
                mac_en  = 1'b1;
                mac_clr = 1'b1;
            end
            ST_MAC1: begin
                mac_a    = x_q[1];
                mac_b    = x_q[4];
                mac_coef = HB1_C2;
                mac_en   = 1'b1;
            end
            ST_MAC2: begin
                mac_a    = x_q[2];
                mac_b    = x_q[3];
                mac_coef = HB1_C4;
                mac_en   = 1'b1;
            end
            default: ;
        endcase
    end

    hb_preadd_mac #(
        .DW(DW),
        .CW(CW),
        .AW(AW)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (mac_en),
        .clr      (mac_clr),
        .a        (mac_a),
        .b        (mac_b),
        .coef     (mac_coef),
        .acc_next (acc_next)
    );

    // y0 is taken from the final MAC sum in the same cycle so it can be
    // registered straight into m_data when OUT0 begins.
    assign acc_rnd = acc_next + RND_HALF;
    assign y0_full = acc_rnd >>> RND_SHIFT;

`ifdef HB_INTERP_SAT_EN
    localparam logic signed [AW-1:0] OUT_MAX = AW'((longint'(1) <<< (DW - 1)) - 1);
    localparam logic signed [AW-1:0] OUT_MIN = -OUT_MAX - 1;

    always_comb begin
        if (y0_full > OUT_MAX) begin
            y0 = {1'b0, {(DW-1){1'b1}}};
        end else if (y0_full < OUT_MIN) begin
            y0 = {1'b1, {(DW-1){1'b0}}};
        end else begin
            y0 = y0_full[DW-1:0];
        end
    end
`else
    logic unused_y0_hi;
    assign unused_y0_hi = ^y0_full[AW-1:DW];
    assign y0 = y0_full[DW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            for (int i = 0; i < 6; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d == ST_IDLE);
            m_valid_q <= (state_d == ST_OUT0) || (state_d == ST_OUT1);
            if (state_q == ST_IDLE && s_valid) begin
                for (int i = 5; i > 0; i--) begin
                    x_q[i] <= x_q[i-1];
                end
                x_q[0] <= s_data;
            end
            if (state_q == ST_MAC2) begin
                m_data_q <= y0;
            end else if (state_q == ST_OUT0 && m_ready) begin
                m_data_q <= x_q[2];
            end
        end
    end

endmodule

// File: tb/tb_hb_interp2.sv
// Self-checking bench for hb_interp2: directed impulse/DC/saturation/
// backpressure/timing/reset scenarios plus randomized traffic, all checked
// against a sample-history model of the halfband equations.
module tb_hb_interp2;

    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    hb_interp2 dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    longint        hist[6];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    bit            rand_done;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic longint to_out(input longint v);
`ifdef HB_INTERP_SAT_EN
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
`else
        longint w;
        w = v & 64'h3FFFF;
        if (w >= 131072) w = w - 262144;
        return w;
`endif
    endfunction

    // Halfband branch A from the six most recent inputs; taps are the Q1.20
    // prototype values, the doubling and rounding folded into >>> 19.
    function automatic longint model_y0();
        longint acc;
        acc = 64'sd8336   * (hist[0] + hist[5])
            - 64'sd57000  * (hist[1] + hist[4])
            + 64'sd310840 * (hist[2] + hist[3]);
        return to_out((acc + 64'sd262144) >>> 19);
    endfunction

    // Model update and per-cycle compare, sampled away from the active edge.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst) begin
            foreach (hist[i]) hist[i] = 0;
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (s_valid && s_ready) begin
                for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = $signed(s_data);
                exp_q.push_back(DW'(model_y0()));
                exp_q.push_back(DW'(hist[2]));
            end
            if (prev_stall) begin
                check(m_valid === 1'b1 && m_data === prev_data, "hold_stable",
                      $signed(m_data), $signed(prev_data));
            end
            if (m_valid) check(s_ready === 1'b0, "s_ready_busy", s_ready, 0);
            if (m_valid && m_ready) begin
                check(exp_q.size() > 0, "extra_output", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(m_data === e, "m_data", $signed(m_data), $signed(e));
                    got_q.push_back(m_data);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [DW-1:0] v);
        bit done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
        end
        check(done, "s_ready_timeout", done, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && s_ready && !m_valid) done = 1'b1;
        end
        check(done, "drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check(m_valid === 1'b0, "rst_m_valid", m_valid, 0);
            check(m_data === '0, "rst_m_data", $signed(m_data), 0);
            check(s_ready === 1'b1, "rst_s_ready", s_ready, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_impulse();
        int imp[14];
        imp = '{1042, 0, -7125, 0, 38855, 65536, 38855, 0, -7125, 0, 1042, 0, 0, 0};
        got_q.delete();
        m_ready = 1'b1;
        send(18'd65536);
        repeat (6) send('0);
        drain();
        check(got_q.size() == 14, "impulse_count", got_q.size(), 14);
        for (int i = 0; i < 14 && i < got_q.size(); i++) begin
            check($signed(got_q[i]) == imp[i], "impulse_value", $signed(got_q[i]), imp[i]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        logic [DW-1:0] held;
        int            sat_y0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        do_reset();

        // Impulse response from clean history.
        run_impulse();

        // DC gain: steady (10001, 10000) once all six taps see the level.
        got_q.delete();
        repeat (12) send(18'd10000);
        drain();
        check(got_q.size() == 24, "dc_count", got_q.size(), 24);
        for (int p = 5; p < 12 && 2 * p + 1 < got_q.size(); p++) begin
            check($signed(got_q[2*p]) == 10001, "dc_y0", $signed(got_q[2*p]), 10001);
            check($signed(got_q[2*p+1]) == 10000, "dc_y1", $signed(got_q[2*p+1]), 10000);
        end

        // Full-scale DC overflows branch A.
`ifdef HB_INTERP_SAT_EN
        sat_y0 = 131071;
`else
        sat_y0 = -131057;
`endif
        got_q.delete();
        repeat (10) send(18'd131071);
        drain();
        check(got_q.size() == 20, "sat_count", got_q.size(), 20);
        if (got_q.size() == 20) begin
            check($signed(got_q[18]) == sat_y0, "sat_y0", $signed(got_q[18]), sat_y0);
            check($signed(got_q[19]) == 131071, "sat_y1", $signed(got_q[19]), 131071);
        end

        // Backpressure during OUT0.
        got_q.delete();
        m_ready = 1'b0;
        send(18'd5000);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (m_valid) seen = 1'b1;
            end
            check(seen, "bp_m_valid_rise", m_valid, 1);
        end
        held = m_data;
        repeat (5) begin
            @(negedge clk);
            check(m_valid === 1'b1, "bp_m_valid", m_valid, 1);
            check(m_data === held, "bp_m_data", $signed(m_data), $signed(held));
            check(s_ready === 1'b0, "bp_s_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();
        check(got_q.size() == 2, "bp_count", got_q.size(), 2);

        // Cycle timing with m_ready held high.
        send(18'd777);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                check(m_valid === 1'b0, "tm_m_valid_low", m_valid, 0);
                check(s_ready === 1'b0, "tm_s_ready_low", s_ready, 0);
            end else if (c <= 5) begin
                check(m_valid === 1'b1, "tm_m_valid_high", m_valid, 1);
            end else begin
                check(m_valid === 1'b0, "tm_m_valid_end", m_valid, 0);
                check(s_ready === 1'b1, "tm_s_ready_back", s_ready, 1);
            end
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random gaps and random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    case ($urandom_range(0, 5))
                        0:       v = 18'h1FFFF;
                        1:       v = 18'h20000;
                        default: v = DW'($urandom);
                    endcase
                    repeat ($urandom_range(0, 4)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(v);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_ready = 1'b1;
        drain();

        // Reset in MAC1 with nonzero history, then a clean impulse.
        send(18'd12345);
        @(posedge clk);
        #1;
        do_reset();
        run_impulse();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
